harry_hazard_monitor: RTL and testbench



---
 rtl/pitfall_pkg.sv | 45 ++++
 rtl/hazard_box_check.sv | 58 +++++
 rtl/harry_hazard_monitor.sv | 141 ++++++++++++++
 tb/tb_harry_hazard_monitor.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pitfall_pkg.sv
// ============================================================================
//  Module      : pitfall_pkg
//  Description : Shared types, screen constants and box-bound helpers for the
//                Pitfall hazard path.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pitfall_pkg;

  localparam int COORD_W  = 10;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int CNT_W    = 16;

  typedef enum logic [1:0] {
    ST_ALIVE     = 2'd0,
    ST_DYING     = 2'd1,
    ST_RESPAWN   = 2'd2,
    ST_GAME_OVER = 2'd3
  } hazard_state_t;

  // Lower box edge, clamped at 0 when the extent reaches past the origin.
  function automatic logic [COORD_W-1:0] lo_bound(
    input logic [COORD_W-1:0] c,
    input logic [COORD_W-1:0] s
  );
    logic [COORD_W:0] d;
    d = {1'b0, c} - {1'b0, s};
    return d[COORD_W] ? '0 : d[COORD_W-1:0];
  endfunction

  // Upper box edge, saturated at the top of the coordinate range.
  function automatic logic [COORD_W-1:0] hi_bound(
    input logic [COORD_W-1:0] c,
    input logic [COORD_W-1:0] s
  );
    logic [COORD_W:0] d;
    d = {1'b0, c} + {1'b0, s};
    return d[COORD_W] ? '1 : d[COORD_W-1:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_box_check.sv
// ============================================================================
//  Module      : hazard_box_check
//  Description : Combinational clamp-and-compare of Harry's box against the
//                pit span and the log box.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_box_check
  import pitfall_pkg::*;
#(
  parameter int LOG_HW = 8,
  parameter int LOG_HH = 8
) (
  input  logic [COORD_W-1:0] i_x,
  input  logic [COORD_W-1:0] i_y,
  input  logic [COORD_W-1:0] i_sx,
  input  logic [COORD_W-1:0] i_sy,
  input  logic               i_pit_en,
  input  logic [COORD_W-1:0] i_pit_x0,
  input  logic [COORD_W-1:0] i_pit_x1,
  input  logic [COORD_W-1:0] i_pit_y,
  input  logic               i_log_en,
  input  logic [COORD_W-1:0] i_log_x,
  input  logic [COORD_W-1:0] i_log_y,
  output logic               o_pit_hit,
  output logic               o_log_hit
);

  localparam logic [COORD_W-1:0] c_log_hw = COORD_W'(LOG_HW);
  localparam logic [COORD_W-1:0] c_log_hh = COORD_W'(LOG_HH);

  logic [COORD_W-1:0] w_x_lo, w_x_hi, w_y_lo, w_y_hi;
  logic [COORD_W-1:0] w_lx_lo, w_lx_hi, w_ly_lo, w_ly_hi;

  assign w_x_lo  = lo_bound(i_x, i_sx);
  assign w_x_hi  = hi_bound(i_x, i_sx);
  assign w_y_lo  = lo_bound(i_y, i_sy);
  assign w_y_hi  = hi_bound(i_y, i_sy);

  assign w_lx_lo = lo_bound(i_log_x, c_log_hw);
  assign w_lx_hi = hi_bound(i_log_x, c_log_hw);
  assign w_ly_lo = lo_bound(i_log_y, c_log_hh);
  assign w_ly_hi = hi_bound(i_log_y, c_log_hh);

  // Harry falls only when his whole width sits inside the pit span.
  assign o_pit_hit = i_pit_en
                   && (i_pit_x0 <= w_x_lo)
                   && (w_x_hi   <= i_pit_x1)
                   && (w_y_hi   >= i_pit_y);

  assign o_log_hit = i_log_en
                   && (w_x_lo <= w_lx_hi) && (w_x_hi >= w_lx_lo)
                   && (w_y_lo <= w_ly_hi) && (w_y_hi >= w_ly_lo);

endmodule

`default_nettype wire

// File: rtl/harry_hazard_monitor.sv
// ============================================================================
//  Module      : harry_hazard_monitor
//  Description : Per-frame hazard FSM owning lives, score, the death sequence
//                and the post-respawn invulnerability window.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module harry_hazard_monitor
  import pitfall_pkg::*;
#(
  parameter int START_LIVES   = 3,
  parameter int SCORE_INIT    = 2000,
  parameter int LOG_PENALTY   = 1,
  parameter int DEATH_FRAMES  = 90,
  parameter int INVULN_FRAMES = 60,
  parameter int LOG_HW        = 8,
  parameter int LOG_HH        = 8
) (
  input  logic               frame_clk,
  input  logic               Reset,
  input  logic [COORD_W-1:0] HarryX,
  input  logic [COORD_W-1:0] HarryY,
  input  logic [COORD_W-1:0] HarryS_X,
  input  logic [COORD_W-1:0] HarryS_Y,
  input  logic               new_level,
  input  logic               pit_en,
  input  logic [COORD_W-1:0] PitX0,
  input  logic [COORD_W-1:0] PitX1,
  input  logic [COORD_W-1:0] PitY,
  input  logic               log_en,
  input  logic [COORD_W-1:0] LogX,
  input  logic [COORD_W-1:0] LogY,
  output logic               harry_death,
  output logic               freeze,
  output logic [1:0]         lives,
  output logic [15:0]        score,
  output logic               game_over,
  output logic               invuln
);

  localparam logic [1:0]       c_lives_init = 2'(START_LIVES);
  localparam logic [15:0]      c_score_init = 16'(SCORE_INIT);
  localparam logic [15:0]      c_penalty    = 16'(LOG_PENALTY);
  localparam logic [CNT_W-1:0] c_death_last = CNT_W'(DEATH_FRAMES - 1);
  localparam logic [CNT_W-1:0] c_invuln     = CNT_W'(INVULN_FRAMES);

  hazard_state_t    r_state, w_state_nx;
  logic [1:0]       r_lives, w_lives_nx;
  logic [15:0]      r_score, w_score_nx;
  logic [CNT_W-1:0] r_death_cnt, w_death_cnt_nx;
  logic [CNT_W-1:0] r_inv_cnt, w_inv_cnt_nx;
  logic             w_pit_hit, w_log_hit, w_invuln;

  hazard_box_check #(
    .LOG_HW (LOG_HW),
    .LOG_HH (LOG_HH)
  ) u_box (
    .i_x      (HarryX),
    .i_y      (HarryY),
    .i_sx     (HarryS_X),
    .i_sy     (HarryS_Y),
    .i_pit_en (pit_en),
    .i_pit_x0 (PitX0),
    .i_pit_x1 (PitX1),
    .i_pit_y  (PitY),
    .i_log_en (log_en),
    .i_log_x  (LogX),
    .i_log_y  (LogY),
    .o_pit_hit(w_pit_hit),
    .o_log_hit(w_log_hit)
  );

  assign w_invuln = (r_inv_cnt != '0);

  always_comb begin
    w_state_nx     = r_state;
    w_lives_nx     = r_lives;
    w_score_nx     = r_score;
    w_death_cnt_nx = r_death_cnt;
    w_inv_cnt_nx   = r_inv_cnt;
    case (r_state)
      ST_ALIVE: begin
        if (w_invuln) w_inv_cnt_nx = r_inv_cnt - 1'b1;
        // A level transition masks both hazards for its frame.
        if (!new_level) begin
          if (w_pit_hit && !w_invuln) begin
            w_state_nx     = ST_DYING;
            w_lives_nx     = (r_lives != 2'd0) ? r_lives - 2'd1 : 2'd0;
            w_death_cnt_nx = '0;
          end else if (w_log_hit && !w_invuln) begin
            w_score_nx = (r_score >= c_penalty) ? r_score - c_penalty : 16'd0;
          end
        end
      end
      ST_DYING: begin
        if (r_death_cnt == c_death_last) begin
          w_state_nx = (r_lives == 2'd0) ? ST_GAME_OVER : ST_RESPAWN;
        end else begin
          w_death_cnt_nx = r_death_cnt + 1'b1;
        end
      end
      ST_RESPAWN: begin
        w_state_nx   = ST_ALIVE;
        w_inv_cnt_nx = c_invuln;
      end
      ST_GAME_OVER: begin
        w_state_nx = ST_GAME_OVER;
      end
      default: begin
        w_state_nx = ST_ALIVE;
      end
    endcase
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      r_state     <= ST_ALIVE;
      r_lives     <= c_lives_init;
      r_score     <= c_score_init;
      r_death_cnt <= '0;
      r_inv_cnt   <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_lives     <= w_lives_nx;
      r_score     <= w_score_nx;
      r_death_cnt <= w_death_cnt_nx;
      r_inv_cnt   <= w_inv_cnt_nx;
    end
  end

  assign harry_death = (r_state == ST_RESPAWN);
  assign freeze      = (r_state == ST_DYING) || (r_state == ST_GAME_OVER);
  assign game_over   = (r_state == ST_GAME_OVER);
  assign invuln      = w_invuln;
  assign lives       = r_lives;
  assign score       = r_score;

endmodule

`default_nettype wire

// File: tb/tb_harry_hazard_monitor.sv
// ============================================================================
//  Module      : tb_harry_hazard_monitor
//  Description : Directed test-plan scenarios plus randomized frames checked
//                against a countdown-based behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_harry_hazard_monitor;

  localparam int P_LIVES = 3;
  localparam int P_SCORE = 2000;
  localparam int P_PEN   = 1;
  localparam int P_DF    = 90;
  localparam int P_INV   = 60;
  localparam int P_HW    = 8;
  localparam int P_HH    = 8;

  logic       frame_clk = 1'b0;
  logic       Reset;
  logic [9:0] HarryX, HarryY, HarryS_X, HarryS_Y;
  logic       new_level, pit_en, log_en;
  logic [9:0] PitX0, PitX1, PitY, LogX, LogY;
  logic       harry_death, freeze, game_over, invuln;
  logic [1:0] lives;
  logic [15:0] score;

  always #5 frame_clk = ~frame_clk;

  harry_hazard_monitor #(
    .START_LIVES  (P_LIVES),
    .SCORE_INIT   (P_SCORE),
    .LOG_PENALTY  (P_PEN),
    .DEATH_FRAMES (P_DF),
    .INVULN_FRAMES(P_INV),
    .LOG_HW       (P_HW),
    .LOG_HH       (P_HH)
  ) dut (
    .frame_clk  (frame_clk),
    .Reset      (Reset),
    .HarryX     (HarryX),
    .HarryY     (HarryY),
    .HarryS_X   (HarryS_X),
    .HarryS_Y   (HarryS_Y),
    .new_level  (new_level),
    .pit_en     (pit_en),
    .PitX0      (PitX0),
    .PitX1      (PitX1),
    .PitY       (PitY),
    .log_en     (log_en),
    .LogX       (LogX),
    .LogY       (LogY),
    .harry_death(harry_death),
    .freeze     (freeze),
    .lives      (lives),
    .score      (score),
    .game_over  (game_over),
    .invuln     (invuln)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: remaining lives/score plus countdowns of frames left in each phase.
  int m_lives, m_score, m_dying_left, m_invuln_left;
  bit m_respawn, m_over;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic int lo_b(int c, int s);
    return (c - s < 0) ? 0 : c - s;
  endfunction

  function automatic int hi_b(int c, int s);
    return (c + s > 1023) ? 1023 : c + s;
  endfunction

  function automatic bit model_pit();
    return pit_en && (int'(PitX0) <= lo_b(HarryX, HarryS_X))
                  && (hi_b(HarryX, HarryS_X) <= int'(PitX1))
                  && (hi_b(HarryY, HarryS_Y) >= int'(PitY));
  endfunction

  function automatic bit model_log();
    return log_en
      && lo_b(HarryX, HarryS_X) <= hi_b(LogX, P_HW) && hi_b(HarryX, HarryS_X) >= lo_b(LogX, P_HW)
      && lo_b(HarryY, HarryS_Y) <= hi_b(LogY, P_HH) && hi_b(HarryY, HarryS_Y) >= lo_b(LogY, P_HH);
  endfunction

  task automatic model_reset();
    m_lives = P_LIVES; m_score = P_SCORE;
    m_dying_left = 0; m_invuln_left = 0;
    m_respawn = 0; m_over = 0;
  endtask

  task automatic model_step();
    bit shielded;
    if (Reset) begin
      model_reset();
    end else if (m_over) begin
      // terminal
    end else if (m_dying_left > 0) begin
      m_dying_left--;
      if (m_dying_left == 0) begin
        if (m_lives == 0) m_over = 1;
        else m_respawn = 1;
      end
    end else if (m_respawn) begin
      m_respawn = 0;
      m_invuln_left = P_INV;
    end else begin
      shielded = (m_invuln_left > 0);
      if (shielded) m_invuln_left--;
      if (!new_level && !shielded) begin
        if (model_pit()) begin
          m_lives--;
          m_dying_left = P_DF;
        end else if (model_log()) begin
          m_score = (m_score - P_PEN < 0) ? 0 : m_score - P_PEN;
        end
      end
    end
  endtask

  task automatic check_outputs();
    check_val("harry_death", harry_death, m_respawn);
    check_val("freeze", freeze, (m_dying_left > 0) || m_over);
    check_val("game_over", game_over, m_over);
    check_val("invuln", invuln, m_invuln_left > 0);
    check_val("lives", lives, m_lives);
    check_val("score", score, m_score);
  endtask

  task automatic frame();
    @(posedge frame_clk);
    model_step();
    #1;
    check_outputs();
  endtask

  task automatic idle_inputs();
    Reset = 0; new_level = 0; pit_en = 0; log_en = 0;
    HarryX = 10'd500; HarryY = 10'd100; HarryS_X = 10'd16; HarryS_Y = 10'd32;
    PitX0 = 10'd180; PitX1 = 10'd220; PitY = 10'd300;
    LogX = 10'd110; LogY = 10'd300;
  endtask

  task automatic do_reset();
    Reset = 1; frame(); Reset = 0;
  endtask

  task automatic rand_inputs();
    int x0, x1;
    Reset     = ($urandom_range(0, 399) == 0);
    new_level = ($urandom_range(0, 9) == 0);
    if ($urandom_range(0, 15) == 0) begin
      x0 = $urandom_range(0, 900);
      x1 = x0 + $urandom_range(0, 300);
      if (x1 > 1023) x1 = 1023;
      PitX0 = 10'(x0); PitX1 = 10'(x1);
      PitY = 10'($urandom_range(0, 1023));
      LogX = 10'($urandom_range(0, 1023));
      LogY = 10'($urandom_range(0, 1023));
      pit_en = ($urandom_range(0, 3) != 0);
      log_en = ($urandom_range(0, 1) != 0);
    end
    if ($urandom_range(0, 1) == 0) begin
      x0 = (int'(PitX0) + int'(PitX1)) / 2 + $urandom_range(0, 40) - 20;
      HarryX = 10'((x0 < 0) ? 0 : (x0 > 1023 ? 1023 : x0));
    end else begin
      HarryX = 10'($urandom_range(0, 1023));
    end
    HarryY   = 10'($urandom_range(0, 1023));
    HarryS_X = ($urandom_range(0, 31) == 0) ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(0, 30));
    HarryS_Y = 10'($urandom_range(0, 60));
  endtask

  initial begin
    int pulses, pulse_at, inv_frames, score_hold;
    idle_inputs();
    model_reset();
    do_reset();
    check_val("reset_lives", lives, 3);
    check_val("reset_score", score, 2000);

    // Log contact for five frames.
    HarryX = 10'd100; HarryY = 10'd280; log_en = 1;
    repeat (5) frame();
    check_val("log_score", score, 1995);
    check_val("log_lives", lives, 3);
    check_val("log_freeze", freeze, 0);

    // Pit edge: left edge 179 is outside the pit.
    log_en = 0; pit_en = 1; HarryX = 10'd195;
    frame();
    check_val("pit_edge_freeze", freeze, 0);

    // Level transition masks the pit.
    HarryX = 10'd200; new_level = 1;
    frame();
    check_val("newlvl_freeze", freeze, 0);
    new_level = 0;

    // Full death / respawn / invulnerability sequence.
    frame();
    check_val("pit_freeze", freeze, 1);
    check_val("pit_lives", lives, 2);
    pulses = 0; pulse_at = -1; inv_frames = 0;
    for (int k = 1; k <= 152; k++) begin
      frame();
      if (harry_death) begin pulses++; pulse_at = k; end
      if (invuln) inv_frames++;
    end
    check_val("death_pulses", pulses, 1);
    check_val("death_pulse_at", pulse_at, 90);
    check_val("invuln_frames", inv_frames, 60);
    check_val("redeath_freeze", freeze, 1);
    check_val("redeath_lives", lives, 1);

    // Remaining deaths lead to game over with a single further respawn.
    pulses = 0;
    repeat (400) begin
      frame();
      if (harry_death) pulses++;
    end
    check_val("go_pulses", pulses, 1);
    check_val("go_flag", game_over, 1);
    check_val("go_freeze", freeze, 1);
    check_val("go_lives", lives, 0);
    score_hold = score;
    pit_en = 0; log_en = 1; HarryX = 10'd100;
    repeat (10) frame();
    check_val("go_score_hold", score, score_hold);

    // Reset mid-DYING.
    do_reset();
    log_en = 0; pit_en = 1; HarryX = 10'd200;
    frame();
    check_val("mid_dying_freeze", freeze, 1);
    pit_en = 0;
    repeat (20) frame();
    do_reset();
    check_val("rst_freeze", freeze, 0);
    check_val("rst_lives", lives, 3);
    check_val("rst_score", score, 2000);
    check_val("rst_death", harry_death, 0);
    check_val("rst_go", game_over, 0);
    check_val("rst_invuln", invuln, 0);

    // Score saturation at zero.
    log_en = 1; HarryX = 10'd100;
    repeat (2010) frame();
    check_val("score_floor", score, 0);

    // Randomized frames.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      rand_inputs();
      frame();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
